// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed scan driver for a 4-digit common-anode 7-segment display.
//   A prescaler divides i_sysclk into DIV-cycle digit slots. Each slot starts
//   with GUARD dark cycles, which suppress ghosting between digits. The
//   displayed value is snapshotted once per frame, so one frame never mixes
//   digits from two counter values.
// Ports:
//   i_sysclk    system clock, rising edge
//   i_sysrst    asynchronous active-high reset
//   i_cnt_data  16-bit value to display; digit k = bits [4k+3:4k]
//   i_dp        per-digit decimal point, active-high
//   i_blank     1 = all digits off
//   o_an        digit anodes, active-low, bit 0 = rightmost digit
//   o_seg       segments {g,f,e,d,c,b,a}, active-low
//   o_dp        decimal point segment, active-low
module seg7_scan_driver #(
  parameter logic [15:0] DIV   = 16'd50000,
  parameter logic [15:0] GUARD = 16'd1000,
  parameter logic        LZB   = 1'b0
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic [15:0] i_cnt_data,
  input  logic [3:0]  i_dp,
  input  logic        i_blank,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp
);

  logic [15:0] r_div;
  logic [1:0]  r_idx;
  logic [15:0] r_snap;

  logic        tick;
  logic        in_guard;
  logic [3:0]  lz_mask;
  logic [3:0]  nibble;
  logic [6:0]  seg_dec;
  logic        active;

  assign tick     = (r_div == DIV - 16'd1);
  assign in_guard = (r_div < GUARD);

  // A digit is a leading zero when it and every higher digit are zero.
  // Digit 0 always stays lit so that a value of zero still shows "0".
  always_comb begin
    lz_mask    = '0;
    lz_mask[1] = LZB && (r_snap[15:4]  == 12'h000);
    lz_mask[2] = LZB && (r_snap[15:8]  == 8'h00);
    lz_mask[3] = LZB && (r_snap[15:12] == 4'h0);
  end

  always_comb begin
    nibble = r_snap[3:0];
    case (r_idx)
      2'd0: nibble = r_snap[3:0];
      2'd1: nibble = r_snap[7:4];
      2'd2: nibble = r_snap[11:8];
      2'd3: nibble = r_snap[15:12];
      default: nibble = r_snap[3:0];
    endcase
  end

  always_comb begin
    seg_dec = 7'b1111111;
    case (nibble)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'b1111111;
    endcase
  end

  // Every dark condition (global blank, guard window, leading-zero) forces
  // anode, segments and decimal point off together.
  assign active = !i_blank && !in_guard && !lz_mask[r_idx];

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      r_div  <= '0;
      r_idx  <= '0;
      r_snap <= '0;
      o_an   <= '1;
      o_seg  <= '1;
      o_dp   <= 1'b1;
    end else begin
      r_div <= tick ? '0 : r_div + 16'd1;
      if (tick) begin
        r_idx <= r_idx + 2'd1;
        // Load on the frame wrap so the next frame shows one coherent value.
        if (r_idx == 2'd3)
          r_snap <= i_cnt_data;
      end
      o_an  <= active ? ~(4'b0001 << r_idx) : '1;
      o_seg <= active ? seg_dec : '1;
      o_dp  <= active ? ~i_dp[r_idx] : 1'b1;
    end
  end

endmodule
